// File: rtl/vector_data_memory.sv
// Scalar/vector data memory: per-colour pixel banks, a descriptor word region, and a GPIO pixel FIFO.
// Reads return one cycle after acceptance; channel writes stall while the GPIO FIFO is full.
module vector_data_memory #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 32,
  parameter int ELEM_W     = 8,
  parameter int CHANNELS   = 3,
  parameter int BANK_DEPTH = 40000,
  parameter int DESC_DEPTH = 1000,
  parameter int FIFO_DEPTH = 8,
  localparam int BUS_W     = LANES * LANE_W,
  localparam int CHW       = $clog2(CHANNELS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic                      re,
  input  logic                      vf,
  input  logic [31:0]               addr,
  input  logic [BUS_W-1:0]          wd,
  output logic [BUS_W-1:0]          rd,
  output logic                      rd_valid,
  output logic                      stall,
  output logic                      err,
  output logic [LANES*ELEM_W-1:0]   gpio_data,
  output logic [CHW-1:0]            gpio_ch,
  output logic                      gpio_vf,
  output logic                      gpio_valid,
  input  logic                      gpio_ready
);

  localparam int CW = $clog2(CHANNELS * BANK_DEPTH);
  localparam int DW = $clog2(DESC_DEPTH);
  localparam logic [32:0] CH_END  = 33'(CHANNELS * BANK_DEPTH);
  localparam logic [32:0] DSC_END = 33'(CHANNELS * BANK_DEPTH + DESC_DEPTH);

  typedef struct packed {
    logic [CHW-1:0]          ch;
    logic [LANES*ELEM_W-1:0] elems;
    logic                    vf;
  } gpio_ent_t;

  logic [ELEM_W-1:0] mem_ch  [CHANNELS*BANK_DEPTH];
  logic [LANE_W-1:0] mem_dsc [DESC_DEPTH];

  logic [32:0]      addr_x;
  logic [32:0]      base_hi;
  logic             base_ch;
  logic             base_dsc;
  logic [CHW-1:0]   base_chn;
  logic [LANES-1:0] lane_act;
  logic [LANES-1:0] lane_ok;
  logic [CW-1:0]    ch_idx  [LANES];
  logic [DW-1:0]    dsc_idx [LANES];
  logic [31:0]      dsc_off;
  logic             unused_dsc_off;
  logic             any_bad;
  logic             acc_rd;
  logic             fifo_full;
  logic             push_vld;
  logic             pop_vld;
  logic [BUS_W-1:0] rd_nxt;
  gpio_ent_t        push_dat;
  gpio_ent_t        pop_dat;

  assign addr_x         = {1'b0, addr};
  assign dsc_off        = addr - CH_END[31:0];
  assign unused_dsc_off = ^dsc_off[31:DW];

  // Every lane is checked against the region that lane 0 falls in.
  always_comb begin
    base_ch  = 1'b0;
    base_dsc = 1'b0;
    base_chn = '0;
    base_hi  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (addr_x >= 33'(c * BANK_DEPTH) && addr_x < 33'((c + 1) * BANK_DEPTH)) begin
        base_ch  = 1'b1;
        base_chn = CHW'(c);
        base_hi  = 33'((c + 1) * BANK_DEPTH);
      end
    end
    if (addr_x >= CH_END && addr_x < DSC_END) begin
      base_dsc = 1'b1;
      base_hi  = DSC_END;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_act[i] = (i == 0) || vf;
      lane_ok[i]  = lane_act[i] && (base_ch || base_dsc) && ((addr_x + 33'(i)) < base_hi);
      ch_idx[i]   = addr[CW-1:0] + CW'(i);
      dsc_idx[i]  = dsc_off[DW-1:0] + DW'(i);
    end
  end

  assign any_bad = |(lane_act & ~lane_ok);
  assign stall   = we && base_ch && fifo_full;
  assign acc_rd  = re && !stall;

  always_ff @(posedge clk) begin
    if (we && !stall) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_ok[i] && base_ch)
          mem_ch[ch_idx[i]] <= wd[i*LANE_W +: ELEM_W];
        if (lane_ok[i] && base_dsc)
          mem_dsc[dsc_idx[i]] <= wd[i*LANE_W +: LANE_W];
      end
    end
  end

  // Write-first: a simultaneous write forwards its data straight into the read.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_ok[i] && base_ch)
        rd_nxt[i*LANE_W +: LANE_W] = LANE_W'(we ? wd[i*LANE_W +: ELEM_W] : mem_ch[ch_idx[i]]);
      else if (lane_ok[i] && base_dsc)
        rd_nxt[i*LANE_W +: LANE_W] = we ? wd[i*LANE_W +: LANE_W] : mem_dsc[dsc_idx[i]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd       <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= acc_rd;
      if (acc_rd)
        rd <= rd_nxt;
      if ((we || re) && !stall && any_bad)
        err <= 1'b1;
    end
  end

  assign push_vld = we && base_ch && !fifo_full;

  always_comb begin
    push_dat    = '0;
    push_dat.ch = base_chn;
    push_dat.vf = vf;
    for (int i = 0; i < LANES; i++) begin
      if (lane_ok[i])
        push_dat.elems[i*ELEM_W +: ELEM_W] = wd[i*LANE_W +: ELEM_W];
    end
  end

  vdm_fifo #(
    .W     ($bits(gpio_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_gpio_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .full     (fifo_full),
    .pop_vld  (pop_vld),
    .pop_rdy  (gpio_ready),
    .pop_dat  (pop_dat)
  );

  assign gpio_valid = pop_vld;
  assign gpio_data  = pop_dat.elems;
  assign gpio_ch    = pop_dat.ch;
  assign gpio_vf    = pop_dat.vf;

endmodule

// Generic power-of-two FIFO; head is zero while empty.
// Head visible in the cycle after push; pushes while full are ignored, head held until pop_rdy.
module vdm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         full,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == AW1'(DEPTH));
  assign pop_vld = (cnt != '0);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && pop_rdy;
  assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + AW1'(do_push) - AW1'(do_pop);
    end
  end

endmodule

// File: tb/tb_vector_data_memory.sv
// Directed bench for vector_data_memory with hand-computed expectations.
module tb_vector_data_memory;
  localparam int BUS_W = 128;

  logic              clk, rst_n, we, re, vf;
  logic [31:0]       addr;
  logic [BUS_W-1:0]  wd, rd;
  logic              rd_valid, stall, err;
  logic [31:0]       gpio_data;
  logic [1:0]        gpio_ch;
  logic              gpio_vf, gpio_valid, gpio_ready;
  int                n_cmp, n_bad;

  vector_data_memory dut (
    .clk(clk), .rst_n(rst_n), .we(we), .re(re), .vf(vf), .addr(addr), .wd(wd),
    .rd(rd), .rd_valid(rd_valid), .stall(stall), .err(err),
    .gpio_data(gpio_data), .gpio_ch(gpio_ch), .gpio_vf(gpio_vf),
    .gpio_valid(gpio_valid), .gpio_ready(gpio_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; vf = 1'b0; addr = '0; wd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gpio_ready = 1'b0; idle();
    #2;
    n_cmp++; if (rd !== '0) begin n_bad++; $display("FAIL reset_rd: got %h want 0", rd); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (gpio_valid !== 1'b0) begin n_bad++; $display("FAIL reset_gpio_valid: got %b want 0", gpio_valid); end
    n_cmp++; if ({gpio_data, gpio_ch, gpio_vf} !== '0) begin n_bad++; $display("FAIL reset_gpio_head: got %h/%h/%b want 0", gpio_data, gpio_ch, gpio_vf); end
    step(); step();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_scalar();
    we = 1'b1; vf = 1'b0; addr = 32'd5; wd = {32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1234_56AB};
    step();
    idle(); re = 1'b1; addr = 32'd5;
    step();
    n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL scalar_rd_valid: got %b want 1", rd_valid); end
    n_cmp++; if (rd !== 128'hAB) begin n_bad++; $display("FAIL scalar_rd: got %h want ab", rd); end
    n_cmp++; if (gpio_valid !== 1'b1) begin n_bad++; $display("FAIL scalar_gpio_valid: got %b want 1", gpio_valid); end
    n_cmp++; if (gpio_ch !== 2'd0 || gpio_vf !== 1'b0) begin n_bad++; $display("FAIL scalar_gpio_ch_vf: got %0d/%b want 0/0", gpio_ch, gpio_vf); end
    n_cmp++; if (gpio_data !== 32'h0000_00AB) begin n_bad++; $display("FAIL scalar_gpio_data: got %h want 000000ab", gpio_data); end
    idle();
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL scalar_rd_valid_drop: got %b want 0", rd_valid); end
    gpio_ready = 1'b1;
    step();
    gpio_ready = 1'b0;
    n_cmp++; if (gpio_valid !== 1'b0) begin n_bad++; $display("FAIL scalar_drain: got %b want 0", gpio_valid); end
  endtask

  task automatic test_vector();
    we = 1'b1; vf = 1'b1; addr = 32'd40000; wd = {32'h44, 32'h33, 32'h22, 32'h11};
    step();
    idle(); re = 1'b1; vf = 1'b1; addr = 32'd40000;
    step();
    n_cmp++; if (rd !== {32'h44, 32'h33, 32'h22, 32'h11}) begin n_bad++; $display("FAIL vector_rd: got %h want 44/33/22/11", rd); end
    n_cmp++; if (gpio_ch !== 2'd1 || gpio_vf !== 1'b1) begin n_bad++; $display("FAIL vector_gpio_ch_vf: got %0d/%b want 1/1", gpio_ch, gpio_vf); end
    n_cmp++; if (gpio_data !== 32'h4433_2211) begin n_bad++; $display("FAIL vector_gpio_data: got %h want 44332211", gpio_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL vector_err: got %b want 0", err); end
    idle(); gpio_ready = 1'b1;
    step();
    gpio_ready = 1'b0;
  endtask

  task automatic test_write_first();
    we = 1'b1; re = 1'b1; vf = 1'b1; addr = 32'd20; wd = {32'h04, 32'h03, 32'h02, 32'h01};
    step();
    n_cmp++; if (rd_valid !== 1'b1 || rd !== {32'h04, 32'h03, 32'h02, 32'h01}) begin n_bad++; $display("FAIL wf_first: got %b/%h want 1/04030201", rd_valid, rd); end
    wd = {32'h14, 32'h13, 32'h12, 32'h11};
    step();
    n_cmp++; if (rd !== {32'h14, 32'h13, 32'h12, 32'h11}) begin n_bad++; $display("FAIL wf_second: got %h want 14131211", rd); end
    idle(); gpio_ready = 1'b1;
    step(); step();
    gpio_ready = 1'b0;
    n_cmp++; if (gpio_valid !== 1'b0) begin n_bad++; $display("FAIL wf_drain: got %b want 0", gpio_valid); end
  endtask

  task automatic test_descriptor();
    we = 1'b1; vf = 1'b1; addr = 32'd120000;
    wd = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF};
    step();
    n_cmp++; if (gpio_valid !== 1'b0) begin n_bad++; $display("FAIL desc_no_push: got %b want 0", gpio_valid); end
    idle(); re = 1'b1; vf = 1'b1; addr = 32'd120000;
    step();
    n_cmp++; if (rd !== {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF}) begin n_bad++; $display("FAIL desc_rd: got %h want deadbeef cafef00d 01234567 89abcdef", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL desc_err: got %b want 0", err); end
    idle();
  endtask

  task automatic test_crossing();
    we = 1'b1; vf = 1'b1; addr = 32'd39998; wd = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
    step();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL cross_err: got %b want 1", err); end
    n_cmp++; if (gpio_data !== 32'h0000_B2A1 || gpio_ch !== 2'd0) begin n_bad++; $display("FAIL cross_gpio: got %h/%0d want 0000b2a1/0", gpio_data, gpio_ch); end
    idle(); re = 1'b1; vf = 1'b1; addr = 32'd39998;
    step();
    n_cmp++; if (rd !== {32'h0, 32'h0, 32'hB2, 32'hA1}) begin n_bad++; $display("FAIL cross_rd: got %h want 0/0/b2/a1", rd); end
    vf = 1'b0; addr = 32'd40000;
    step();
    n_cmp++; if (rd !== 128'h11) begin n_bad++; $display("FAIL cross_bank1_intact: got %h want 11", rd); end
    addr = 32'd121000;
    step();
    n_cmp++; if (rd_valid !== 1'b1 || rd !== '0) begin n_bad++; $display("FAIL unmapped_rd: got %b/%h want 1/0", rd_valid, rd); end
    idle(); gpio_ready = 1'b1;
    step();
    gpio_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    gpio_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      we = 1'b1; vf = 1'b0; addr = 32'(100 + k); wd = 128'(80 + k);
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fill_stall_%0d: got %b want 0", k, stall); end
      step();
    end
    we = 1'b1; re = 1'b1; addr = 32'd108; wd = 128'h58;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_stall: got %b want 1", stall); end
    step();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL stalled_read: got %b want 0", rd_valid); end
    n_cmp++; if (gpio_data !== 32'h50) begin n_bad++; $display("FAIL head_hold: got %h want 50", gpio_data); end
    gpio_ready = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL pop_same_cycle_stall: got %b want 1", stall); end
    step();
    gpio_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0 || gpio_data !== 32'h51) begin n_bad++; $display("FAIL after_pop: got %b/%h want 0/51", stall, gpio_data); end
    step();
    n_cmp++; if (rd_valid !== 1'b1 || rd !== 128'h58) begin n_bad++; $display("FAIL ninth_accept: got %b/%h want 1/58", rd_valid, rd); end
    idle(); gpio_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n_cmp++; if (gpio_valid !== 1'b1 || gpio_data !== 32'(80 + k)) begin n_bad++; $display("FAIL drain_%0d: got %b/%h want 1/%h", k, gpio_valid, gpio_data, 32'(80 + k)); end
      step();
    end
    n_cmp++; if (gpio_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", gpio_valid); end
    gpio_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    gpio_ready = 1'b1;
    we = 1'b1; vf = 1'b0; addr = 32'd200; wd = 128'h70;
    step();
    n_cmp++; if (gpio_data !== 32'h70) begin n_bad++; $display("FAIL b2b_first: got %h want 70", gpio_data); end
    addr = 32'd201; wd = 128'h71;
    step();
    n_cmp++; if (gpio_valid !== 1'b1 || gpio_data !== 32'h71) begin n_bad++; $display("FAIL b2b_push_pop: got %b/%h want 1/71", gpio_valid, gpio_data); end
    idle();
    step();
    n_cmp++; if (gpio_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", gpio_valid); end
    gpio_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    gpio_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      we = 1'b1; vf = 1'b0; addr = 32'(300 + k); wd = 128'(144 + k);
      step();
    end
    idle(); re = 1'b1; addr = 32'd300;
    step();
    n_cmp++; if (rd_valid !== 1'b1 || gpio_valid !== 1'b1 || err !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got %b/%b/%b want 1/1/1", rd_valid, gpio_valid, err); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (gpio_valid !== 1'b0 || rd_valid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL async_reset: got %b/%b/%b want 0/0/0", gpio_valid, rd_valid, err); end
    n_cmp++; if (rd !== '0 || gpio_data !== '0) begin n_bad++; $display("FAIL async_reset_data: got %h/%h want 0/0", rd, gpio_data); end
    idle();
    step();
    rst_n = 1'b1;
    we = 1'b1; re = 1'b1; vf = 1'b0; addr = 32'd7; wd = 128'h99;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL post_reset_stall: got %b want 0", stall); end
    step();
    n_cmp++; if (rd_valid !== 1'b1 || rd !== 128'h99) begin n_bad++; $display("FAIL post_reset_rd: got %b/%h want 1/99", rd_valid, rd); end
    n_cmp++; if (gpio_valid !== 1'b1 || gpio_data !== 32'h99) begin n_bad++; $display("FAIL post_reset_gpio: got %b/%h want 1/99", gpio_valid, gpio_data); end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_scalar();
    test_vector();
    test_write_first();
    test_descriptor();
    test_crossing();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_data_memory.md
VECTOR_DATA_MEMORY -- requirements
Module: vector_data_memory

Interface
REQ-001 Parameter LANES, default 4, vector lanes per access.
REQ-002 Parameter LANE_W, default 32, bits per lane; bus width BUS_W = LANES*LANE_W.
REQ-003 Parameter ELEM_W, default 8, pixel element width, held in lane bits [ELEM_W-1:0].
REQ-004 Parameter CHANNELS, default 3, colour channels.
REQ-005 Parameter BANK_DEPTH, default 40000, elements per channel.
REQ-006 Parameter DESC_DEPTH, default 1000, LANE_W-bit words in the descriptor region.
REQ-007 Parameter FIFO_DEPTH, default 8, power of two, GPIO output FIFO entries.
REQ-008 clk  in  1  sole clock; all state updates on rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 we  in  1  write enable.
REQ-011 re  in  1  read request.
REQ-012 vf  in  1  1 = vector access (LANES lanes), 0 = scalar (lane 0 only).
REQ-013 addr  in  32  element/word address.
REQ-014 wd  in  BUS_W  write data, lane i in bits [i*LANE_W +: LANE_W].
REQ-015 rd  out  BUS_W  registered read data.
REQ-016 rd_valid  out  1  rd holds data for the re issued one cycle earlier.
REQ-017 stall  out  1  combinational; access not accepted this cycle, core holds request.
REQ-018 err  out  1  sticky out-of-range flag.
REQ-019 gpio_data  out  LANES*ELEM_W  FIFO head pixel elements.
REQ-020 gpio_ch  out  $clog2(CHANNELS+1)  FIFO head channel index.
REQ-021 gpio_vf  out  1  FIFO head vector flag; if 0 only element 0 is meaningful.
REQ-022 gpio_valid / gpio_ready  out / in  1 / 1  ready-valid handshake on FIFO head.

Function
REQ-023 Map: channel c occupies [c*BANK_DEPTH, (c+1)*BANK_DEPTH); descriptor region [CHANNELS*BANK_DEPTH, +DESC_DEPTH); anything else is unmapped.
REQ-024 Lane i addresses addr+i; scalar access uses lane 0 only.
REQ-025 Channel write stores wd lane bits [ELEM_W-1:0]; channel read returns element zero-extended to LANE_W per lane.
REQ-026 Descriptor write/read uses the full LANE_W per lane.
REQ-027 Lane whose address leaves the base region of addr (bank crossing or unmapped): write dropped, read lane = 0, err set; other lanes unaffected.
REQ-028 Read latency exactly 1 cycle: re accepted at edge N -> rd/rd_valid valid after edge N; rd_valid low the following cycle absent a new re.
REQ-029 we and re on the same accepted cycle: read returns the newly written value (write-first).
REQ-030 Accepted channel-region write pushes {channel, lane elements, vf} into the GPIO FIFO; descriptor writes do not push.
REQ-031 stall = we & channel region & FIFO full; on stall, no memory write, no push, no read, rd_valid low next cycle.
REQ-032 Pop when gpio_valid & gpio_ready; gpio_valid = FIFO not empty; head outputs stable while gpio_valid & !gpio_ready.
REQ-033 Pop and stall-causing write in the same cycle when full: stall still asserted (based on registered full); write accepted next cycle.
REQ-034 Push and pop same cycle when not full and not empty: count unchanged, order preserved.
REQ-035 FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-036 err cleared only by reset.

Reset
REQ-037 rst_n low asynchronously clears rd=0, rd_valid=0, err=0, FIFO empty, gpio_valid=0, gpio_data=0, gpio_ch=0, gpio_vf=0.
REQ-038 Memory arrays are not reset; contents undefined until written.
REQ-039 Reset asserted mid-operation discards in-flight read and all FIFO entries; first access after release is accepted normally.

Verification
REQ-040 Scalar write 0xAB to addr 5, re addr 5 -> rd lane0 = 0x000000AB, rd_valid one cycle later; FIFO head ch=0, vf=0, element0=0xAB.
REQ-041 Vector write lanes 0x11,0x22,0x33,0x44 at addr 40000 -> channel 1 elems 0..3 set; vector read returns them; gpio_ch=1.
REQ-042 Vector write at addr 39998 -> lanes 0,1 stored, lanes 2,3 dropped, err=1; read at 39998 returns lanes 2,3 = 0.
REQ-043 gpio_ready=0, 9 channel writes -> writes 1-8 accepted, 9th stall=1; gpio_ready=1 one cycle -> 9th accepted next cycle, order preserved.
REQ-044 Descriptor vector write 0xDEADBEEF.. at 120000 -> read back full 32-bit lanes, no FIFO push.
REQ-045 rst_n low with 3 FIFO entries and pending read -> gpio_valid=0, rd_valid=0, err=0 immediately, without a clock edge.
